puf_scan_controller: RTL and testbench



---
 rtl/puf_scan_controller.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_puf_scan_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_scan_controller.sv
// puf_scan_controller
//   Scan-chain controller for an arbiter PUF. Shifts a challenge pair into
//   the PUF, waits a settle interval, pulses the trigger, then shifts out
//   N_RESP response chains and presents them with a done/valid handshake.
//   The PUF phase clocks ph1/ph2 are registered outputs. They come from a
//   free-running frame counter. Everything runs on clk.
//
// Optional build macro: PUF_SCAN_READBACK_EN
//   When it is defined, the controller checks the challenge chain echoes
//   (ca_out/cb_out) during RECEIVE. It reports any mismatch on readback_err.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   start, abort        run request (IDLE only) / abort of a run in progress
//   challenge_a/b       challenge words, latched when start is accepted
//   busy, done          run in progress / one-cycle completion pulse
//   resp_valid          response holds a complete result
//   response            chain k at [k*CHAL_W +: CHAL_W]
//   so_in               serial outputs of the response chains
//   ph1, ph2            non-overlapping phase clocks to the PUF
//   ca_si, cb_si        serial challenge data (LSB first)
//   ph_en, out_en       input-shift / output-shift enables
//   trig                PUF evaluation trigger
//   ca_out, cb_out      challenge chain echoes      (readback build only)
//   readback_err        echo mismatch seen in run   (readback build only)
//
// FSM states
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | waiting for start
//   SYNC     | waiting for frame boundary
//   SEND     | shifting challenge bits, ph_en=1
//   SETTLE   | SETTLE_FR quiet frames
//   TRIG     | trig=1 for TRIG_FR frames
//   HOLD     | one quiet frame after trigger
//   RECEIVE  | capturing response bits, out_en=1
//   DONE     | done pulse, response valid
module puf_scan_controller #(
  parameter int CHAL_W    = 128,
  parameter int N_RESP    = 4,
  parameter int PH_DIV    = 1,
  parameter int SETTLE_FR = 6,
  parameter int TRIG_FR   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CHAL_W-1:0]          challenge_a,
  input  logic [CHAL_W-1:0]          challenge_b,
  output logic                       busy,
  output logic                       done,
  output logic                       resp_valid,
  output logic [N_RESP*CHAL_W-1:0]   response,
  input  logic [N_RESP-1:0]          so_in,
`ifdef PUF_SCAN_READBACK_EN
  input  logic                       ca_out,
  input  logic                       cb_out,
  output logic                       readback_err,
`endif
  output logic                       ph1,
  output logic                       ph2,
  output logic                       ca_si,
  output logic                       cb_si,
  output logic                       ph_en,
  output logic                       out_en,
  output logic                       trig
);

  localparam int FRAME   = 4 * PH_DIV;
  localparam int POS_W   = $clog2(FRAME);
  localparam int BIT_W   = $clog2(CHAL_W) + 1;
  localparam int IDX_W   = $clog2(CHAL_W);
  localparam int TMR_MAX = (SETTLE_FR > TRIG_FR) ? SETTLE_FR : TRIG_FR;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_SEND, S_SETTLE, S_TRIG, S_HOLD, S_RECEIVE, S_DONE
  } state_t;

  // Phase generator
  logic [POS_W-1:0] pos, pos_nxt;
  logic             frame_tick;

  assign frame_tick = (pos == POS_W'(FRAME - 1));
  assign pos_nxt    = frame_tick ? '0 : pos + 1'b1;

  // ph1/ph2 are decoded from the next frame position. The registered
  // outputs therefore line up exactly with the quarter the counter is in.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= '0;
      ph1 <= 1'b0;
      ph2 <= 1'b0;
    end else begin
      pos <= pos_nxt;
      ph1 <= (pos_nxt < POS_W'(PH_DIV));
      ph2 <= (pos_nxt >= POS_W'(2 * PH_DIV)) && (pos_nxt < POS_W'(3 * PH_DIV));
    end
  end

  // Sequencer
  state_t                    state, state_nxt;
  logic [BIT_W-1:0]          bit_cnt, bit_nxt, bit_inc;
  logic [IDX_W-1:0]          idx, idx_inc;
  logic [TMR_W-1:0]          tmr, tmr_nxt;
  logic [CHAL_W-1:0]         chal_a, chal_a_nxt, chal_b, chal_b_nxt;
  logic [N_RESP*CHAL_W-1:0]  response_nxt;
  logic                      busy_nxt, done_nxt, resp_valid_nxt;
  logic                      ca_si_nxt, cb_si_nxt, ph_en_nxt, out_en_nxt, trig_nxt;
  logic                      last_bit;
`ifdef PUF_SCAN_READBACK_EN
  logic                      err, err_nxt, readback_err_nxt;
`endif

  assign bit_inc  = bit_cnt + 1'b1;
  assign idx      = bit_cnt[IDX_W-1:0];
  assign idx_inc  = bit_inc[IDX_W-1:0];
  assign last_bit = (bit_cnt == BIT_W'(CHAL_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      tmr        <= '0;
      chal_a     <= '0;
      chal_b     <= '0;
      response   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      resp_valid <= 1'b0;
      ca_si      <= 1'b0;
      cb_si      <= 1'b0;
      ph_en      <= 1'b0;
      out_en     <= 1'b0;
      trig       <= 1'b0;
`ifdef PUF_SCAN_READBACK_EN
      err          <= 1'b0;
      readback_err <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_nxt;
      tmr        <= tmr_nxt;
      chal_a     <= chal_a_nxt;
      chal_b     <= chal_b_nxt;
      response   <= response_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      resp_valid <= resp_valid_nxt;
      ca_si      <= ca_si_nxt;
      cb_si      <= cb_si_nxt;
      ph_en      <= ph_en_nxt;
      out_en     <= out_en_nxt;
      trig       <= trig_nxt;
`ifdef PUF_SCAN_READBACK_EN
      err          <= err_nxt;
      readback_err <= readback_err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_nxt        = bit_cnt;
    tmr_nxt        = tmr;
    chal_a_nxt     = chal_a;
    chal_b_nxt     = chal_b;
    response_nxt   = response;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    resp_valid_nxt = resp_valid;
    ca_si_nxt      = ca_si;
    cb_si_nxt      = cb_si;
    ph_en_nxt      = ph_en;
    out_en_nxt     = out_en;
    trig_nxt       = trig;
`ifdef PUF_SCAN_READBACK_EN
    err_nxt          = err;
    readback_err_nxt = readback_err;
`endif

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          chal_a_nxt     = challenge_a;
          chal_b_nxt     = challenge_b;
          resp_valid_nxt = 1'b0;
          busy_nxt       = 1'b1;
          state_nxt      = S_SYNC;
`ifdef PUF_SCAN_READBACK_EN
          err_nxt          = 1'b0;
          readback_err_nxt = 1'b0;
`endif
        end
      end
      S_SYNC: begin
        if (frame_tick) begin
          state_nxt = S_SEND;
          bit_nxt   = '0;
          ph_en_nxt = 1'b1;
          ca_si_nxt = chal_a[0];
          cb_si_nxt = chal_b[0];
        end
      end
      S_SEND: begin
        if (frame_tick) begin
          if (last_bit) begin
            ph_en_nxt = 1'b0;
            ca_si_nxt = 1'b0;
            cb_si_nxt = 1'b0;
            tmr_nxt   = TMR_W'(SETTLE_FR - 1);
            state_nxt = S_SETTLE;
          end else begin
            bit_nxt   = bit_inc;
            ca_si_nxt = chal_a[idx_inc];
            cb_si_nxt = chal_b[idx_inc];
          end
        end
      end
      S_SETTLE: begin
        if (frame_tick) begin
          if (tmr == '0) begin
            trig_nxt  = 1'b1;
            tmr_nxt   = TMR_W'(TRIG_FR - 1);
            state_nxt = S_TRIG;
          end else begin
            tmr_nxt = tmr - 1'b1;
          end
        end
      end
      S_TRIG: begin
        if (frame_tick) begin
          if (tmr == '0) begin
            trig_nxt  = 1'b0;
            state_nxt = S_HOLD;
          end else begin
            tmr_nxt = tmr - 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (frame_tick) begin
          bit_nxt    = '0;
          out_en_nxt = 1'b1;
          state_nxt  = S_RECEIVE;
        end
      end
      S_RECEIVE: begin
        if (frame_tick) begin
          for (int k = 0; k < N_RESP; k++) begin
            for (int b = 0; b < CHAL_W; b++) begin
              if (bit_cnt == BIT_W'(b)) response_nxt[k*CHAL_W + b] = so_in[k];
            end
          end
`ifdef PUF_SCAN_READBACK_EN
          if ((ca_out != chal_a[idx]) || (cb_out != chal_b[idx])) err_nxt = 1'b1;
`endif
          if (last_bit) begin
            out_en_nxt     = 1'b0;
            done_nxt       = 1'b1;
            resp_valid_nxt = 1'b1;
            busy_nxt       = 1'b0;
            state_nxt      = S_DONE;
`ifdef PUF_SCAN_READBACK_EN
            readback_err_nxt = err_nxt;
`endif
          end else begin
            bit_nxt = bit_inc;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides the sequencer. Bits already captured stay in response,
    // but resp_valid is left unchanged (it was cleared at start).
    if (abort && (state != S_IDLE)) begin
      state_nxt      = S_IDLE;
      busy_nxt       = 1'b0;
      done_nxt       = 1'b0;
      resp_valid_nxt = resp_valid;
      response_nxt   = response;
      ph_en_nxt      = 1'b0;
      out_en_nxt     = 1'b0;
      trig_nxt       = 1'b0;
      ca_si_nxt      = 1'b0;
      cb_si_nxt      = 1'b0;
    end
  end

endmodule

// File: tb/tb_puf_scan_controller.sv
module tb_puf_scan_controller;

  localparam int CW     = 8;
  localparam int NR     = 2;
  localparam int PD     = 1;
  localparam int SF     = 6;
  localparam int TF     = 1;
  localparam int F      = 4 * PD;
  localparam int RUN_FR = 2 * CW + SF + TF + 1;
  localparam int PD2    = 2;
  localparam int F2     = 4 * PD2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic [CW-1:0] challenge_a = '0, challenge_b = '0;
  logic [NR-1:0] so_in = '0;
  logic busy, done, resp_valid, ph1, ph2, ca_si, cb_si, ph_en, out_en, trig;
  logic [NR*CW-1:0] response;

  logic start2 = 1'b0, abort2 = 1'b0;
  logic [CW-1:0] challenge_a2 = '0, challenge_b2 = '0;
  logic [NR-1:0] so_in2 = '0;
  logic busy2, done2, resp_valid2, ph1_2, ph2_2, ca_si2, cb_si2, ph_en2, out_en2, trig2;
  logic [NR*CW-1:0] response2;
`ifdef PUF_SCAN_READBACK_EN
  logic ca_out = 1'b0, cb_out = 1'b0, readback_err;
  logic ca_out2 = 1'b0, cb_out2 = 1'b0, readback_err2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;

  puf_scan_controller #(.CHAL_W(CW), .N_RESP(NR), .PH_DIV(PD), .SETTLE_FR(SF), .TRIG_FR(TF)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .challenge_a(challenge_a), .challenge_b(challenge_b),
    .busy(busy), .done(done), .resp_valid(resp_valid), .response(response),
    .so_in(so_in),
`ifdef PUF_SCAN_READBACK_EN
    .ca_out(ca_out), .cb_out(cb_out), .readback_err(readback_err),
`endif
    .ph1(ph1), .ph2(ph2), .ca_si(ca_si), .cb_si(cb_si),
    .ph_en(ph_en), .out_en(out_en), .trig(trig)
  );

  puf_scan_controller #(.CHAL_W(CW), .N_RESP(NR), .PH_DIV(PD2), .SETTLE_FR(SF), .TRIG_FR(TF)) u_div2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .challenge_a(challenge_a2), .challenge_b(challenge_b2),
    .busy(busy2), .done(done2), .resp_valid(resp_valid2), .response(response2),
    .so_in(so_in2),
`ifdef PUF_SCAN_READBACK_EN
    .ca_out(ca_out2), .cb_out(cb_out2), .readback_err(readback_err2),
`endif
    .ph1(ph1_2), .ph2(ph2_2), .ca_si(ca_si2), .cb_si(cb_si2),
    .ph_en(ph_en2), .out_en(out_en2), .trig(trig2)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the phase generator free-runs from this.
  always @(posedge clk) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_phase(input int fr, input int pd, input logic p1, input logic p2, input string name);
    int  pos;
    logic [1:0] exp_p;
    if (ecnt > 0) begin
      pos   = ecnt % fr;
      exp_p = {pos < pd, (pos >= 2 * pd) && (pos < 3 * pd)};
      n_tests++;
      if ({p1, p2} !== exp_p) begin
        n_fail++;
        $display("FAIL %s phase k=%0d got ph1ph2=%b exp=%b", name, ecnt, {p1, p2}, exp_p);
      end
    end
  endtask

  // One run on the PH_DIV=1 instance, checked cycle by cycle against a frame
  // timeline. abort_frame/reset_e/mid_start_e/bad_bit < 0 disable that event.
  task automatic run_check(input logic [CW-1:0] ca, input logic [CW-1:0] cb, input bit echo,
                           input int mid_start_e, input int abort_frame, input int reset_e,
                           input int bad_bit, input string name);
    logic [NR-1:0]    so_bits [CW];
    logic [NR*CW-1:0] exp_resp;
    logic [7:0]       exp_v, got_v;
    int k0, t0, rs, e, kn, r, k_abort;
    bit aborted, pe;
    for (int i = 0; i < CW; i++) so_bits[i] = echo ? {~cb[i], ca[i]} : NR'($urandom);
    for (int i = 0; i < CW; i++)
      for (int k = 0; k < NR; k++) exp_resp[k*CW + i] = so_bits[i][k];
    challenge_a = ca;
    challenge_b = cb;
    start = 1'b1;
    step();
    start = 1'b0;
    challenge_a = CW'($urandom);
    challenge_b = CW'($urandom);
    k0 = ecnt;
    t0 = k0 + (F - (k0 % F));
    rs = t0 + F * (CW + SF + TF + 1);
    k_abort = (abort_frame >= 0) ? rs + F * abort_frame + 2 : -1;
    aborted = 1'b0;
    for (int c = 0; c < 4 + F * RUN_FR + 3; c++) begin
      e = ecnt - t0;
      if (k_abort >= 0 && ecnt >= k_abort) aborted = 1'b1;
      pe = (e >= 0) && (e < F * CW);
      exp_v = {e < F * RUN_FR, e == F * RUN_FR, e >= F * RUN_FR, pe,
               (e >= F * (CW + SF + TF + 1)) && (e < F * RUN_FR),
               (e >= F * (CW + SF)) && (e < F * (CW + SF + TF)),
               pe ? ca[e / F] : 1'b0, pe ? cb[e / F] : 1'b0};
      if (aborted) exp_v = '0;
      got_v = {busy, done, resp_valid, ph_en, out_en, trig, ca_si, cb_si};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s ctl e=%0d got=%b exp=%b (busy,done,rv,ph_en,out_en,trig,ca,cb)", name, e, got_v, exp_v);
      end
      check_phase(F, PD, ph1, ph2, name);
      if (!aborted && e == F * RUN_FR) begin
        n_tests++;
        if (response !== exp_resp) begin
          n_fail++;
          $display("FAIL %s response got=%h exp=%h", name, response, exp_resp);
        end
`ifdef PUF_SCAN_READBACK_EN
        n_tests++;
        if (readback_err !== (bad_bit >= 0)) begin
          n_fail++;
          $display("FAIL %s readback_err got=%b exp=%b", name, readback_err, bad_bit >= 0);
        end
`endif
      end
      if (reset_e >= 0 && e == reset_e) begin
        reset = 1'b1;
        step();
        n_tests++;
        if ({trig, ph1, ph2, resp_valid, busy, done, ph_en, out_en, ca_si, cb_si} !== 10'b0 || response !== '0) begin
          n_fail++;
          $display("FAIL %s reset_mid_run got trig=%b ph1=%b ph2=%b rv=%b busy=%b resp=%h exp all 0",
                   name, trig, ph1, ph2, resp_valid, busy, response);
        end
        reset = 1'b0;
        return;
      end
      kn = ecnt + 1;
      start = (mid_start_e >= 0) && (e + 1 == mid_start_e);
      if (start) begin
        challenge_a = CW'($urandom);
        challenge_b = CW'($urandom);
      end
      abort = (kn == k_abort);
      if (kn > rs && kn <= rs + F * CW) begin
        r = (kn - rs - 1) / F;
        so_in = so_bits[r];
`ifdef PUF_SCAN_READBACK_EN
        ca_out = ca[r] ^ (r == bad_bit);
        cb_out = cb[r];
`endif
      end else begin
        so_in = NR'($urandom);
`ifdef PUF_SCAN_READBACK_EN
        ca_out = 1'($urandom);
        cb_out = 1'($urandom);
`endif
      end
      step();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({busy, done, resp_valid, ph1, ph2, ca_si, cb_si, ph_en, out_en, trig} !== 10'b0 || response !== '0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%b done=%b rv=%b ph1=%b ph2=%b resp=%h exp all 0",
               busy, done, resp_valid, ph1, ph2, response);
    end
    reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_vector();
    run_check(8'hA5, 8'h3C, 1'b1, -1, -1, -1, -1, "vector");
    repeat (3) step();
    n_tests++;
    if (response !== 16'hC3A5 || resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL vector_hold got resp=%h rv=%b exp resp=c3a5 rv=1", response, resp_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 5)) step();
      run_check(CW'($urandom), CW'($urandom), 1'b0, -1, -1, -1, -1, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_check(CW'($urandom), CW'($urandom), 1'b0, -1, -1, -1, -1, "b2b_first");
    run_check(CW'($urandom), CW'($urandom), 1'b0, -1, -1, -1, -1, "b2b_second");
  endtask

  task automatic test_start_mid_send();
    run_check(CW'($urandom), CW'($urandom), 1'b0, F * 3 + 1, -1, -1, -1, "start_mid_send");
  endtask

  task automatic test_abort();
    run_check(CW'($urandom), CW'($urandom), 1'b0, -1, 3, -1, -1, "abort_recv");
    run_check(CW'($urandom), CW'($urandom), 1'b0, -1, -1, -1, -1, "after_abort");
  endtask

  task automatic test_reset_mid_trig();
    run_check(CW'($urandom), CW'($urandom), 1'b0, -1, -1, F * (CW + SF) + 1, -1, "reset_trig");
    repeat (2) step();
  endtask

  task automatic test_phase_div2();
    int trig_cnt, done_cnt;
    trig_cnt = 0;
    done_cnt = 0;
    challenge_a2 = CW'($urandom);
    challenge_b2 = CW'($urandom);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 0; c < F2 * (RUN_FR + 1) + 8; c++) begin
      check_phase(F2, PD2, ph1_2, ph2_2, "div2");
      if (trig2) trig_cnt++;
      if (done2) done_cnt++;
      so_in2 = NR'($urandom);
      step();
    end
    n_tests++;
    if (trig_cnt != F2 * TF || done_cnt != 1 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL div2_run got trig_cycles=%0d dones=%0d busy=%b exp %0d 1 0", trig_cnt, done_cnt, busy2, F2 * TF);
    end
  endtask

`ifdef PUF_SCAN_READBACK_EN
  task automatic test_readback();
    run_check(8'hA5, 8'h3C, 1'b1, -1, -1, -1, 5, "readback_bad");
    run_check(8'hA5, 8'h3C, 1'b1, -1, -1, -1, -1, "readback_clean");
  endtask
`endif

  initial begin
    test_reset();
    test_vector();
    test_random();
    test_back_to_back();
    test_start_mid_send();
    test_abort();
    test_reset_mid_trig();
    test_phase_div2();
`ifdef PUF_SCAN_READBACK_EN
    test_readback();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
